// File: rtl/ex_mem_stage.sv
`default_nettype none
// ============================================================================
// Module      : ex_mem_stage
// Description : EX/MEM pipeline register with a two-entry skid buffer,
//               flush, branch-taken output and saturating stall counter.
// Revision    : 1.0 - initial release
// ============================================================================
module ex_mem_stage #(
   parameter int DATA_W = 32,
   parameter int REG_W  = 5,
   parameter int WB_W   = 2,
   parameter int CNT_W  = 16
) (
   input  logic              Clk,
   input  logic              Rst_n,
   input  logic              Flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [WB_W-1:0]   WB_in,
   input  logic [2:0]        M_in,
   input  logic [DATA_W-1:0] addResult_in,
   input  logic              ALUZero_in,
   input  logic [DATA_W-1:0] ALUResult_in,
   input  logic [DATA_W-1:0] readReg2_in,
   input  logic [REG_W-1:0]  muxResult_in,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [WB_W-1:0]   WB_out,
   output logic              Branch,
   output logic              MemRead,
   output logic              MemWrite,
   output logic [DATA_W-1:0] addResult_out,
   output logic              ALUZero_out,
   output logic [DATA_W-1:0] ALUResult_out,
   output logic [DATA_W-1:0] readReg2_out,
   output logic [REG_W-1:0]  muxResult_out,
   output logic              PCSrc_out,
   output logic [1:0]        Occ,
   output logic [CNT_W-1:0]  StallCnt
);

   typedef struct packed {
      logic [WB_W-1:0]   wb;
      logic [2:0]        m;
      logic [DATA_W-1:0] add;
      logic              zero;
      logic [DATA_W-1:0] alu;
      logic [DATA_W-1:0] rr2;
      logic [REG_W-1:0]  mux;
   } bundle_t;

   localparam logic [CNT_W-1:0] c_STALL_MAX = {CNT_W{1'b1}};

   bundle_t          r_main;
   bundle_t          r_skid;
   logic             r_main_valid;
   logic             r_skid_valid;
   logic             r_in_ready;
   logic [CNT_W-1:0] r_stall_cnt;

   bundle_t w_in_bundle;
   logic    w_accept;
   logic    w_main_open;
   logic    w_main_valid_nxt;
   logic    w_skid_valid_nxt;
   logic    w_load_main_from_skid;
   logic    w_load_main_from_in;
   logic    w_load_skid;
   logic    w_stalled;

   assign w_in_bundle = '{wb:   WB_in,
                          m:    M_in,
                          add:  addResult_in,
                          zero: ALUZero_in,
                          alu:  ALUResult_in,
                          rr2:  readReg2_in,
                          mux:  muxResult_in};

   // r_in_ready mirrors ~r_skid_valid but is its own flop, so out_ready never
   // reaches in_ready combinationally.
   assign w_accept    = in_valid & r_in_ready;
   assign w_main_open = ~r_main_valid | out_ready;
   assign w_stalled   = r_main_valid & ~out_ready;

   always_comb begin
      w_main_valid_nxt      = r_main_valid;
      w_skid_valid_nxt      = r_skid_valid;
      w_load_main_from_skid = 1'b0;
      w_load_main_from_in   = 1'b0;
      w_load_skid           = 1'b0;
      if (Flush) begin
         w_main_valid_nxt = 1'b0;
         w_skid_valid_nxt = 1'b0;
      end else if (w_main_open) begin
         if (r_skid_valid) begin
            w_main_valid_nxt      = 1'b1;
            w_skid_valid_nxt      = 1'b0;
            w_load_main_from_skid = 1'b1;
         end else if (w_accept) begin
            w_main_valid_nxt    = 1'b1;
            w_load_main_from_in = 1'b1;
         end else begin
            w_main_valid_nxt = 1'b0;
         end
      end else if (w_accept) begin
         w_skid_valid_nxt = 1'b1;
         w_load_skid      = 1'b1;
      end
   end

   always_ff @(posedge Clk) begin
      if (!Rst_n) begin
         r_main       <= '0;
         r_skid       <= '0;
         r_main_valid <= 1'b0;
         r_skid_valid <= 1'b0;
         r_in_ready   <= 1'b1;
         r_stall_cnt  <= '0;
      end else begin
         r_main_valid <= w_main_valid_nxt;
         r_skid_valid <= w_skid_valid_nxt;
         r_in_ready   <= ~w_skid_valid_nxt;
         if (w_load_main_from_skid) begin
            r_main <= r_skid;
         end else if (w_load_main_from_in) begin
            r_main <= w_in_bundle;
         end
         if (w_load_skid) begin
            r_skid <= w_in_bundle;
         end
         // Flush deliberately leaves the stall history intact.
         if (w_stalled && (r_stall_cnt != c_STALL_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 1'b1;
         end
      end
   end

   assign in_ready      = r_in_ready;
   assign out_valid     = r_main_valid;
   assign WB_out        = r_main_valid ? r_main.wb : '0;
   assign Branch        = r_main_valid & r_main.m[2];
   assign MemRead       = r_main_valid & r_main.m[1];
   assign MemWrite      = r_main_valid & r_main.m[0];
   assign addResult_out = r_main.add;
   assign ALUZero_out   = r_main.zero;
   assign ALUResult_out = r_main.alu;
   assign readReg2_out  = r_main.rr2;
   assign muxResult_out = r_main.mux;
   assign PCSrc_out     = r_main_valid & r_main.m[2] & r_main.zero;
   assign Occ           = {1'b0, r_main_valid} + {1'b0, r_skid_valid};
   assign StallCnt      = r_stall_cnt;

endmodule
`default_nettype wire
